axis_segout_serializer_ctrl: RTL and testbench
==============================================

Name: axis_segout_serializer_ctrl

Overview:
- Drain controller for the segmented shift-register output FIFO.
- Walks the FIFO's per-segment output lanes in ascending order and issues per-lane tready pops.
- Re-emits the data as a narrow, one-segment-per-beat AXI stream through a registered output stage.
- Drops null segments (tkeep all zero) and moves tlast/tuser onto the last non-null segment of each input beat; feeds narrow downstream consumers (per-segment parsers, narrow egress ports).

Parameters:
- AXIS_BUS_WIDTH, 64, full width of the upstream segmented bus.
- AXIS_USER_WIDTH, 4, tuser width.
- NUM_SEGMENTS, 4, number of lanes; power of two, >=2.
- AXIS_SEG_WIDTH (local), AXIS_BUS_WIDTH/NUM_SEGMENTS, lane data width.
- NUM_SEG_BYTES (local), AXIS_SEG_WIDTH/8, lane keep width.
- SEG_IDX_BITS (local), $clog2(NUM_SEGMENTS), lane pointer width.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- enable  in  1  run gate; sampled only at beat boundary (ptr==0)
- seg_tdata  in  AXIS_BUS_WIDTH  lane j at [j*AXIS_SEG_WIDTH +: AXIS_SEG_WIDTH]
- seg_tkeep  in  NUM_BUS_BYTES  lane j keep, packed the same way
- seg_tuser  in  AXIS_USER_WIDTH  tuser of lane NUM_SEGMENTS-1 head
- seg_tlast  in  1  tlast of lane NUM_SEGMENTS-1 head
- seg_tvalid  in  NUM_SEGMENTS  per-lane non-empty
- seg_tready  out  NUM_SEGMENTS  per-lane pop, one-hot or zero
- out_tdata  out  AXIS_SEG_WIDTH  narrow data
- out_tkeep  out  NUM_SEG_BYTES  narrow keep
- out_tuser  out  AXIS_USER_WIDTH  narrow user
- out_tlast  out  1  narrow last
- out_tvalid  out  1  narrow valid
- out_tready  in  1  narrow ready
- busy  out  1  ptr != 0 or out_tvalid

Behaviour:
- Reset (async, areset=1): ptr=0, emitted=0, out_tvalid=0, out_tdata/tkeep/tuser/tlast=0, seg_tready=0. Reset mid-beat discards the partial beat; upstream FIFO state is the upstream's responsibility.
- ptr: current lane index. Lanes ptr..N-1 hold the current beat at their heads; lanes <ptr hold the next beat.
- load_ok = !out_tvalid || out_tready (single output register, no skid).
- act = seg_tvalid[ptr] && load_ok && (ptr!=0 || enable).
- seg_tready[ptr] = act, combinational; all other bits 0. The controller never pops a lane other than ptr.
- trail_null = seg_tkeep of all lanes above ptr are zero (false when ptr==N-1).
- keep_cur = |seg_tkeep lane ptr.
- emit = act && (keep_cur || (ptr==N-1 && seg_tlast && !emitted)).
- On emit: out_* <= lane ptr data/keep; out_tlast <= seg_tlast && (trail_null || ptr==N-1); out_tuser <= seg_tuser; out_tvalid <= 1; emitted <= 1.
- On act without emit (null lane): pop only; output register keeps its state, except out_tvalid <= 0 if out_tready.
- On act: ptr <= ptr+1, wrapping N-1 -> 0; on the wrap, emitted <= 0.
- If !act and out_tready: out_tvalid <= 0.
- Throughput: one lane per cycle, including null lanes; latency 1 cycle from pop to out_tvalid.
- All-null beat with tlast: exactly one output beat (tkeep=0, tlast=1) on lane N-1. All-null beat without tlast: zero output beats, N pops.
- enable=0 with ptr!=0: the current beat still drains to completion; the block halts at ptr==0.
- out_tvalid=1 && out_tready=0: out_* held stable, no pops (AXI stability).
- Simultaneous drain (out_tready) and load in the same cycle: new data is loaded and out_tvalid stays 1.

Test Plan:
- N=4, SEG_WIDTH=16; one beat tkeep=0xFF (full), tlast=1, out_tready=1 -> 4 outputs on consecutive cycles, lanes 0..3 data in order, out_tlast only on the 4th, seg_tready one-hot 0001,0010,0100,1000.
- Beat tkeep=0x0F, tlast=1 -> 2 outputs, out_tlast=1 on lane 1 data; lanes 2,3 popped silently; ptr returns to 0 after 4 acts.
- Beat tkeep=0x00, tlast=1, tuser=0xA -> single output tkeep=0, tlast=1, tuser=0xA after 4 pops; tlast=0 variant -> no output.
- Backpressure: out_tready low for 5 cycles mid-beat -> out_* stable, seg_tready=0 throughout, no data loss or duplication vs. scoreboard.
- enable dropped while ptr=2 -> lanes 2,3 still drain, ptr=0, busy falls once the output drains; next beat held until enable=1.
- areset asserted while ptr=3, out_tvalid=1 -> same-cycle out_tvalid=0, seg_tready=0, ptr=0; first post-reset pop is on lane 0.

Source files
------------

// File: rtl/axis_segout_serializer_ctrl.sv
// Drains a segmented output FIFO lane by lane into a narrow AXI stream.
// Null lanes are popped silently; tlast/tuser land on the last non-null lane of a beat.
module axis_segout_serializer_ctrl #(
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_USER_WIDTH = 4,
    parameter int NUM_SEGMENTS    = 4
) (
    input  logic                                     aclk,
    input  logic                                     areset,
    input  logic                                     enable,
    input  logic [AXIS_BUS_WIDTH-1:0]                seg_tdata,
    input  logic [AXIS_BUS_WIDTH/8-1:0]              seg_tkeep,
    input  logic [AXIS_USER_WIDTH-1:0]               seg_tuser,
    input  logic                                     seg_tlast,
    input  logic [NUM_SEGMENTS-1:0]                  seg_tvalid,
    output logic [NUM_SEGMENTS-1:0]                  seg_tready,
    output logic [AXIS_BUS_WIDTH/NUM_SEGMENTS-1:0]   out_tdata,
    output logic [AXIS_BUS_WIDTH/NUM_SEGMENTS/8-1:0] out_tkeep,
    output logic [AXIS_USER_WIDTH-1:0]               out_tuser,
    output logic                                     out_tlast,
    output logic                                     out_tvalid,
    input  logic                                     out_tready,
    output logic                                     busy
);

    localparam int AXIS_SEG_WIDTH = AXIS_BUS_WIDTH / NUM_SEGMENTS;
    localparam int NUM_SEG_BYTES  = AXIS_SEG_WIDTH / 8;
    localparam int SEG_IDX_BITS   = $clog2(NUM_SEGMENTS);

    logic [SEG_IDX_BITS-1:0]   ptr;
    logic [SEG_IDX_BITS-1:0]   ptr_nxt;
    logic                      emitted;
    logic                      emitted_nxt;
    logic [AXIS_SEG_WIDTH-1:0] cur_data;
    logic [NUM_SEG_BYTES-1:0]  cur_keep;
    logic                      trail_any;
    logic                      trail_null;
    logic                      last_lane;
    logic                      load_ok;
    logic                      act;
    logic                      emit;

    always_comb begin
        cur_data  = '0;
        cur_keep  = '0;
        trail_any = 1'b0;
        for (int j = 0; j < NUM_SEGMENTS; j++) begin
            if (ptr == SEG_IDX_BITS'(j)) begin
                cur_data = seg_tdata[j*AXIS_SEG_WIDTH +: AXIS_SEG_WIDTH];
                cur_keep = seg_tkeep[j*NUM_SEG_BYTES +: NUM_SEG_BYTES];
            end
            if (SEG_IDX_BITS'(j) > ptr) begin
                trail_any = trail_any | (|seg_tkeep[j*NUM_SEG_BYTES +: NUM_SEG_BYTES]);
            end
        end
    end

    assign last_lane  = (ptr == SEG_IDX_BITS'(NUM_SEGMENTS - 1));
    assign trail_null = !trail_any && !last_lane;
    assign load_ok    = !out_tvalid || out_tready;

    // Gated by reset so no pop can leak out while the pointer is being cleared.
    assign act = !areset && seg_tvalid[ptr] && load_ok
               && ((ptr != '0) || enable);

    // An all-null beat carrying tlast still needs one marker beat on the last lane.
    assign emit = act && ((|cur_keep) || (last_lane && seg_tlast && !emitted));

    assign busy = (ptr != '0) || out_tvalid;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ptr     <= '0;
            emitted <= 1'b0;
        end else begin
            ptr     <= ptr_nxt;
            emitted <= emitted_nxt;
        end
    end

    always_comb begin
        ptr_nxt     = ptr;
        emitted_nxt = emitted;
        if (act) begin
            ptr_nxt     = ptr + SEG_IDX_BITS'(1);
            emitted_nxt = last_lane ? 1'b0 : (emitted || emit);
        end
    end

    always_comb begin
        seg_tready = '0;
        for (int j = 0; j < NUM_SEGMENTS; j++) begin
            seg_tready[j] = act && (ptr == SEG_IDX_BITS'(j));
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_tdata  <= '0;
            out_tkeep  <= '0;
            out_tuser  <= '0;
            out_tlast  <= 1'b0;
            out_tvalid <= 1'b0;
        end else if (emit) begin
            out_tdata  <= cur_data;
            out_tkeep  <= cur_keep;
            out_tuser  <= seg_tuser;
            out_tlast  <= seg_tlast && (trail_null || last_lane);
            out_tvalid <= 1'b1;
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_segout_serializer_ctrl.sv
// Directed bench for axis_segout_serializer_ctrl with N=4, 16-bit lanes.
// A one-beat FIFO model drops lane valid on each pop; accepted outputs are queued.
module tb_axis_segout_serializer_ctrl;

    logic        aclk = 1'b0;
    logic        areset;
    logic        enable;
    logic [63:0] seg_tdata;
    logic [7:0]  seg_tkeep;
    logic [3:0]  seg_tuser;
    logic        seg_tlast;
    logic [3:0]  seg_tvalid;
    logic [3:0]  seg_tready;
    logic [15:0] out_tdata;
    logic [1:0]  out_tkeep;
    logic [3:0]  out_tuser;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int base;

    logic [22:0] got[$];
    logic [3:0]  rlog[$];

    always #5 aclk = ~aclk;

    axis_segout_serializer_ctrl #(
        .AXIS_BUS_WIDTH (64),
        .AXIS_USER_WIDTH(4),
        .NUM_SEGMENTS   (4)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .enable    (enable),
        .seg_tdata (seg_tdata),
        .seg_tkeep (seg_tkeep),
        .seg_tuser (seg_tuser),
        .seg_tlast (seg_tlast),
        .seg_tvalid(seg_tvalid),
        .seg_tready(seg_tready),
        .out_tdata (out_tdata),
        .out_tkeep (out_tkeep),
        .out_tuser (out_tuser),
        .out_tlast (out_tlast),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready),
        .busy      (busy)
    );

    function automatic logic [15:0] lane(input int j);
        return 16'hA0A0 + 16'(j) * 16'h1111;
    endfunction

    function automatic logic [22:0] bt(input logic l, input logic [3:0] u,
                                       input logic [1:0] k, input logic [15:0] d);
        return {l, u, k, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [22:0] exp);
        logic [22:0] obs;
        obs = (idx < got.size()) ? got[idx] : 'x;
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic chk_pop(input string tag, input int idx, input logic [3:0] exp);
        logic [3:0] obs;
        obs = (idx < rlog.size()) ? rlog[idx] : 'x;
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic cyc();
        logic [3:0] popped;
        @(negedge aclk);
        popped = seg_tready;
        rlog.push_back(popped);
        if (out_tvalid && out_tready)
            got.push_back({out_tlast, out_tuser, out_tkeep, out_tdata});
        @(posedge aclk);
        #1;
        seg_tvalid = seg_tvalid & ~popped;
    endtask

    task automatic load(input logic [7:0] k, input logic l, input logic [3:0] u);
        seg_tkeep  = k;
        seg_tlast  = l;
        seg_tuser  = u;
        seg_tvalid = 4'hF;
        got.delete();
        rlog.delete();
    endtask

    initial begin
        areset     = 1'b1;
        enable     = 1'b1;
        out_tready = 1'b1;
        seg_tdata  = 64'hD3D3_C2C2_B1B1_A0A0;
        seg_tkeep  = '0;
        seg_tuser  = '0;
        seg_tlast  = 1'b0;
        seg_tvalid = '0;

        repeat (2) @(posedge aclk);
        #1;
        chk("rst_valid", 64'(out_tvalid), 64'd0);
        chk("rst_ready", 64'(seg_tready), 64'd0);
        chk("rst_busy",  64'(busy),       64'd0);
        chk("rst_data",  64'(out_tdata),  64'd0);
        chk("rst_last",  64'(out_tlast),  64'd0);
        areset = 1'b0;

        // full beat
        load(8'hFF, 1'b1, 4'h5);
        repeat (6) cyc();
        chk("full_cnt", 64'(got.size()), 64'd4);
        for (int j = 0; j < 4; j++) begin
            chk_beat("full_beat", j, bt(j == 3, 4'h5, 2'b11, lane(j)));
            chk_pop("full_pop", j, 4'(1 << j));
        end
        chk("full_busy", 64'(busy), 64'd0);

        // half beat: tlast moves to lane 1
        load(8'h0F, 1'b1, 4'h3);
        repeat (6) cyc();
        chk("half_cnt", 64'(got.size()), 64'd2);
        chk_beat("half_b0", 0, bt(1'b0, 4'h3, 2'b11, 16'hA0A0));
        chk_beat("half_b1", 1, bt(1'b1, 4'h3, 2'b11, 16'hB1B1));
        for (int j = 0; j < 4; j++) chk_pop("half_pop", j, 4'(1 << j));
        chk_pop("half_idle", 4, 4'h0);
        chk("half_busy", 64'(busy), 64'd0);

        // all-null beat with tlast
        load(8'h00, 1'b1, 4'hA);
        repeat (6) cyc();
        chk("null_cnt", 64'(got.size()), 64'd1);
        chk_beat("null_beat", 0, bt(1'b1, 4'hA, 2'b00, 16'hD3D3));
        chk_pop("null_pop3", 3, 4'h8);

        // all-null beat without tlast
        load(8'h00, 1'b0, 4'hA);
        repeat (6) cyc();
        chk("nullnl_cnt", 64'(got.size()), 64'd0);
        for (int j = 0; j < 4; j++) chk_pop("nullnl_pop", j, 4'(1 << j));
        chk("nullnl_busy", 64'(busy), 64'd0);

        // backpressure mid-beat
        load(8'hFF, 1'b1, 4'h7);
        repeat (2) cyc();
        out_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_pop("bp_nopop", 2 + i, 4'h0);
            chk("bp_data",  64'(out_tdata),  64'hB1B1);
            chk("bp_valid", 64'(out_tvalid), 64'd1);
        end
        out_tready = 1'b1;
        repeat (4) cyc();
        chk("bp_cnt", 64'(got.size()), 64'd4);
        for (int j = 0; j < 4; j++)
            chk_beat("bp_beat", j, bt(j == 3, 4'h7, 2'b11, lane(j)));

        // enable dropped at ptr=2
        load(8'hFF, 1'b1, 4'h1);
        repeat (2) cyc();
        enable = 1'b0;
        repeat (3) cyc();
        chk("en_busy", 64'(busy), 64'd0);
        chk("en_cnt", 64'(got.size()), 64'd4);
        chk_beat("en_last", 3, bt(1'b1, 4'h1, 2'b11, 16'hD3D3));
        seg_tvalid = 4'hF;
        base = rlog.size();
        repeat (3) cyc();
        for (int i = 0; i < 3; i++) chk_pop("en_hold", base + i, 4'h0);
        chk("en_hold_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        repeat (6) cyc();
        chk_pop("en_resume", base + 3, 4'h1);
        chk("en_cnt2", 64'(got.size()), 64'd8);

        // async reset at ptr=3 with output pending
        load(8'hFF, 1'b1, 4'h2);
        repeat (3) cyc();
        chk("ar_pre_valid", 64'(out_tvalid), 64'd1);
        areset     = 1'b1;
        seg_tvalid = 4'hF;
        #1;
        chk("ar_valid", 64'(out_tvalid), 64'd0);
        chk("ar_ready", 64'(seg_tready), 64'd0);
        chk("ar_busy",  64'(busy),       64'd0);
        chk("ar_data",  64'(out_tdata),  64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        load(8'hFF, 1'b1, 4'h2);
        repeat (6) cyc();
        chk_pop("ar_first_pop", 0, 4'h1);
        chk("ar_cnt", 64'(got.size()), 64'd4);
        chk_beat("ar_b0", 0, bt(1'b0, 4'h2, 2'b11, 16'hA0A0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
